// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg -- shared definitions for the instruction fetch controller.
//
// Contents:
//   PC_ADDR_W / PC_INSTR_W : default address and instruction widths.
//   fetch_state_t          : FSM state encoding. ST_ERR is only present
//                            when FETCH_TIMEOUT_EN is defined.
//   fetch_req_active()     : true in states that drive a memory request.
package pc_fetch_pkg;

  localparam int PC_ADDR_W  = 8;
  localparam int PC_INSTR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_VALID = 3'd2,
    ST_INC   = 3'd3
`ifdef FETCH_TIMEOUT_EN
    ,
    ST_ERR   = 3'd4
`endif
  } fetch_state_t;

  function automatic logic fetch_req_active(input fetch_state_t st);
    return (st == ST_REQ);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// fetch_timer -- counts cycles a fetch spends waiting for acknowledge.
//
// Ports:
//   i_clk      : clock, rising edge.
//   i_reset_n  : asynchronous active-low reset, clears the count.
//   i_load     : restart the count at zero (asserted while idle).
//   i_count    : advance the count (asserted while requesting).
//   o_expire   : high during the TIMEOUT_CYCLES-th counted cycle.
//
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  // The count runs 0 .. TIMEOUT_CYCLES-1, one value per waiting cycle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= '0;
    end else if (i_count && !o_expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_expire = i_count && (cnt == CNT_LAST);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- instruction fetch sequencer between the PC register,
// instruction memory and the decoder.
//
// One fetch walks IDLE -> REQ -> VALID -> INC -> IDLE: latch the PC, request
// memory until acknowledged, hold the instruction until the decoder takes
// it, then pulse o_incPc so the PC register advances on its falling edge.
//
// Ports:
//   i_clk, i_reset_n        : clock and asynchronous active-low reset.
//   i_pc                    : current PC value.
//   o_memAddr, o_memReq     : memory read address and request.
//   i_memAck, i_memData     : acknowledge with same-cycle read data.
//   o_instr, o_instrValid   : fetched instruction to the decoder.
//   i_instrReady            : decoder accepts o_instr.
//   o_incPc                 : one-cycle PC increment strobe.
//   i_halt                  : blocks new fetches (sampled in IDLE only).
//   o_fetchErr              : sticky acknowledge-timeout flag.
//
// Build option: FETCH_TIMEOUT_EN enables the acknowledge timeout and the ERR
// state; without it REQ waits indefinitely and o_fetchErr is held at 0.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W         = PC_ADDR_W,
  parameter int INSTR_W        = PC_INSTR_W,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [ADDR_W-1:0]  o_memAddr,
  output logic               o_memReq,
  input  logic               i_memAck,
  input  logic [INSTR_W-1:0] i_memData,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instrValid,
  input  logic               i_instrReady,
  output logic               o_incPc,
  input  logic               i_halt,
  output logic               o_fetchErr
);

  fetch_state_t state, state_nxt;
  logic         timer_expire;

`ifdef FETCH_TIMEOUT_EN
  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_load   (state == ST_IDLE),
    .i_count  (state == ST_REQ),
    .o_expire (timer_expire)
  );
`else
  assign timer_expire = 1'b0;
  // The parameter stays on the interface so both builds share one port map.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0) | timer_expire;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!i_halt) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // An acknowledge arriving in the expiring cycle still wins.
        if (i_memAck) begin
          state_nxt = ST_VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timer_expire) begin
          state_nxt = ST_ERR;
        end
`endif
      end
      ST_VALID: begin
        if (i_instrReady) state_nxt = ST_INC;
      end
      ST_INC: begin
        state_nxt = ST_IDLE;
      end
`ifdef FETCH_TIMEOUT_EN
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
`endif
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode: all strobes are pure functions of the state
  always_comb begin
    o_memReq     = fetch_req_active(state);
    o_instrValid = (state == ST_VALID);
    o_incPc      = (state == ST_INC);
`ifdef FETCH_TIMEOUT_EN
    o_fetchErr   = (state == ST_ERR);
`else
    o_fetchErr   = 1'b0;
`endif
  end

  // Address and instruction holding registers. The address is captured only
  // when leaving IDLE, so it stays stable through REQ even if i_pc moves.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_memAddr <= '0;
      o_instr   <= '0;
    end else begin
      if (state == ST_IDLE && !i_halt) begin
        o_memAddr <= i_pc;
      end
      if (state == ST_REQ && i_memAck) begin
        o_instr <= i_memData;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [7:0]  i_pc;
  logic [7:0]  o_memAddr;
  logic        o_memReq;
  logic        i_memAck;
  logic [15:0] i_memData;
  logic [15:0] o_instr;
  logic        o_instrValid;
  logic        i_instrReady;
  logic        o_incPc;
  logic        i_halt;
  logic        o_fetchErr;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [15:0] exp_q[$];

  always #5 i_clk = ~i_clk;

  pc_fetch_ctrl #(
    .ADDR_W(8),
    .INSTR_W(16),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_pc        (i_pc),
    .o_memAddr   (o_memAddr),
    .o_memReq    (o_memReq),
    .i_memAck    (i_memAck),
    .i_memData   (i_memData),
    .o_instr     (o_instr),
    .o_instrValid(o_instrValid),
    .i_instrReady(i_instrReady),
    .o_incPc     (o_incPc),
    .i_halt      (i_halt),
    .o_fetchErr  (o_fetchErr)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop_check(input string tag);
    logic [15:0] e;
    n_asserts++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h expected <entry>", tag, o_instr);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, {16'h0, o_instr}, {16'h0, e});
    end
  endtask

  task automatic check_strobes(input string tag, input logic req, input logic vld, input logic inc);
    check({tag, "_req"}, {31'h0, o_memReq}, {31'h0, req});
    check({tag, "_vld"}, {31'h0, o_instrValid}, {31'h0, vld});
    check({tag, "_inc"}, {31'h0, o_incPc}, {31'h0, inc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset_n    = 1'b0;
    i_pc         = 8'h00;
    i_memAck     = 1'b0;
    i_memData    = 16'h0000;
    i_instrReady = 1'b0;
    i_halt       = 1'b0;
    tick();
    tick();
    check_strobes("rst", 1'b0, 1'b0, 1'b0);
    check("rst_addr", {24'h0, o_memAddr}, 32'h0);
    check("rst_instr", {16'h0, o_instr}, 32'h0);
    check("rst_err", {31'h0, o_fetchErr}, 32'h0);

    // Immediate ack and ready: IDLE, REQ, VALID, INC
    i_reset_n = 1'b1; i_pc = 8'h05; i_memAck = 1'b1; i_memData = 16'h1234;
    i_instrReady = 1'b1;
    exp_q.push_back(16'h1234);
    check_strobes("t1_c0", 1'b0, 1'b0, 1'b0);
    tick();
    check_strobes("t1_c1", 1'b1, 1'b0, 1'b0);
    check("t1_addr", {24'h0, o_memAddr}, 32'h05);
    tick();
    check_strobes("t1_c2", 1'b0, 1'b1, 1'b0);
    sb_pop_check("t1_instr");
    tick();
    check_strobes("t1_c3", 1'b0, 1'b0, 1'b1);
    i_halt = 1'b1;
    tick();
    check_strobes("t1_c4", 1'b0, 1'b0, 1'b0);

    // Ack delayed three cycles; address held while i_pc moves
    i_halt = 1'b0; i_pc = 8'h3C; i_memAck = 1'b0; i_memData = 16'hDEAD;
    tick();
    i_pc = 8'h99;
    for (int i = 0; i < 4; i++) begin
      check("t2_req", {31'h0, o_memReq}, 32'h1);
      check("t2_addr", {24'h0, o_memAddr}, 32'h3C);
      if (i == 3) begin
        i_memAck = 1'b1; i_memData = 16'hA55A;
        exp_q.push_back(16'hA55A);
      end
      tick();
    end
    check_strobes("t2_valid", 1'b0, 1'b1, 1'b0);
    sb_pop_check("t2_instr");
    i_memData = 16'hFFFF;   // ack still high outside REQ: must not capture
    i_halt = 1'b1;
    tick();
    check_strobes("t2_inc", 1'b0, 1'b0, 1'b1);
    check("t2_hold", {16'h0, o_instr}, 32'hA55A);
    i_memAck = 1'b0;
    tick();

    // Decoder stalls five cycles in VALID
    i_halt = 1'b0; i_pc = 8'h77; i_memAck = 1'b1; i_memData = 16'hBEEF;
    i_instrReady = 1'b0;
    exp_q.push_back(16'hBEEF);
    tick();
    i_halt = 1'b1;
    tick();
    i_memData = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check_strobes("t3_stall", 1'b0, 1'b1, 1'b0);
      check("t3_instr", {16'h0, o_instr}, 32'hBEEF);
      tick();
    end
    i_instrReady = 1'b1;
    check_strobes("t3_rdy", 1'b0, 1'b1, 1'b0);
    sb_pop_check("t3_instr_out");
    tick();
    check_strobes("t3_inc", 1'b0, 1'b0, 1'b1);
    i_memAck = 1'b0;
    tick();

    // Halt raised during REQ: fetch completes, then no new request
    i_halt = 1'b0; i_pc = 8'h42; i_instrReady = 1'b1;
    tick();
    i_halt = 1'b1;
    tick();
    check("t4_req", {31'h0, o_memReq}, 32'h1);
    check("t4_addr", {24'h0, o_memAddr}, 32'h42);
    i_memAck = 1'b1; i_memData = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    tick();
    check_strobes("t4_valid", 1'b0, 1'b1, 1'b0);
    sb_pop_check("t4_instr");
    i_memAck = 1'b0;
    tick();
    check_strobes("t4_inc", 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_strobes("t4_halted", 1'b0, 1'b0, 1'b0);
      tick();
    end

    // All-ones PC is fetched as is
    i_halt = 1'b0; i_pc = 8'hFF; i_memAck = 1'b1; i_memData = 16'h8001;
    exp_q.push_back(16'h8001);
    tick();
    check("t5_addr", {24'h0, o_memAddr}, 32'hFF);
    i_halt = 1'b1;
    tick();
    sb_pop_check("t5_instr");
    tick();
    check_strobes("t5_inc", 1'b0, 1'b0, 1'b1);
    tick();

    // Reset pulsed while VALID: everything clears at once, no increment
    i_halt = 1'b0; i_pc = 8'h10; i_memData = 16'hC3C3; i_instrReady = 1'b0;
    tick();
    tick();
    check("t6_valid", {31'h0, o_instrValid}, 32'h1);
    check("t6_instr", {16'h0, o_instr}, 32'hC3C3);
    i_reset_n = 1'b0;
    #1;
    check_strobes("t6_async", 1'b0, 1'b0, 1'b0);
    check("t6_addr", {24'h0, o_memAddr}, 32'h0);
    check("t6_instr0", {16'h0, o_instr}, 32'h0);
    i_instrReady = 1'b1;
    tick();
    check_strobes("t6_hold", 1'b0, 1'b0, 1'b0);
    i_halt = 1'b1; i_memAck = 1'b0;
    i_reset_n = 1'b1;
    tick();
    check_strobes("t6_post", 1'b0, 1'b0, 1'b0);

    // Acknowledge never arrives
    i_halt = 1'b0; i_pc = 8'h20; i_memAck = 1'b0;
    tick();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      check("t7_req", {31'h0, o_memReq}, 32'h1);
      check("t7_err0", {31'h0, o_fetchErr}, 32'h0);
      tick();
    end
    check("t7_err", {31'h0, o_fetchErr}, 32'h1);
    check("t7_noreq", {31'h0, o_memReq}, 32'h0);
    i_memAck = 1'b1; i_instrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t7_sticky", {31'h0, o_fetchErr}, 32'h1);
      check_strobes("t7_quiet", 1'b0, 1'b0, 1'b0);
    end
    i_reset_n = 1'b0;
    #1;
    check("t7_clr", {31'h0, o_fetchErr}, 32'h0);
    i_memAck = 1'b0; i_halt = 1'b1;
    tick();
    i_reset_n = 1'b1;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      check("t7_wait", {31'h0, o_memReq}, 32'h1);
      check("t7_noerr", {31'h0, o_fetchErr}, 32'h0);
      tick();
    end
    i_memAck = 1'b1; i_memData = 16'h5A5A; i_instrReady = 1'b1; i_halt = 1'b1;
    exp_q.push_back(16'h5A5A);
    tick();
    check_strobes("t7_valid", 1'b0, 1'b1, 1'b0);
    sb_pop_check("t7_instr");
    tick();
    check_strobes("t7_inc", 1'b0, 1'b0, 1'b1);
    tick();
`endif
    check("sb_drain", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
